// File: rtl/proc_pkg.sv
// Shared processor constants and the fetch-to-decode entry type.
package proc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for an arbitrary packed entry type; flush beats push/pop.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request issue, prefetch FIFO and redirect flush.
module fetch_unit #(
  parameter int              XLEN       = proc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = proc_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  import proc_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(2 * FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_nxt;
  logic [OW-1:0]   drop_cnt;
  logic [OW-1:0]   reserved;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  // Every live in-flight request owns a FIFO slot; dropped ones do not.
  assign reserved = OW'(fifo_count) + outstanding - drop_cnt;
  assign imem_req_valid = !reset && !fifo_full
                       && (reserved < OW'(FIFO_DEPTH))
                       && (outstanding < OW'(2 * FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_keep        = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop             = if_valid && if_ready && !redirect_valid;
  assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid = !fifo_empty;
  assign if_pc    = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-L memory model plus an in-order instruction stream reference.
module tb_fetch_unit;

  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_hs = 0;
  int          n_pop = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] first_pop_pc = '0;
  logic        got_first = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        s_rv, s_iv, s_rst, s_rd;
  logic [31:0] s_ra, s_rdpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check, advance the edge, update reference and memory.
  task automatic tick();
    logic hs, pop;
    #1;
    s_rv = imem_req_valid; s_ra = imem_req_addr; s_iv = if_valid;
    s_rst = reset; s_rd = redirect_valid; s_rdpc = redirect_pc;
    hs  = s_rv && imem_req_ready;
    pop = s_iv && if_ready;
    if (prev_wait && !s_rst) begin
      chk("req_hold_valid", 32'(s_rv), 32'd1);
      chk("req_hold_addr", s_ra, prev_addr);
    end
    if (hs) chk("req_addr", s_ra, exp_addr);
    if (pop && !s_rd && !s_rst) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, exp_pc ^ KEY);
      if (!got_first) begin first_pop_pc = if_pc; got_first = 1'b1; end
      n_pop++;
    end
    prev_wait = s_rv && !imem_req_ready && !s_rd && !s_rst;
    prev_addr = s_ra;
    @(posedge clk);
    #1;
    if (s_rst) begin
      q_addr.delete(); q_due.delete();
      exp_addr = RST_PC; exp_pc = RST_PC; prev_wait = 1'b0;
    end else begin
      if (hs) begin q_addr.push_back(s_ra); q_due.push_back(cyc + lat); n_hs++; end
      if (s_rd) begin
        exp_addr = s_rdpc & ~32'h3;
        exp_pc   = s_rdpc & ~32'h3;
      end else begin
        if (hs)  exp_addr += 32'd4;
        if (pop) exp_pc   += 32'd4;
      end
    end
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = q_addr[0] ^ KEY;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    chk("inflight_bound", 32'(q_due.size() <= 8), 32'd1);
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; redirect_valid = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0;
    tick();
    chk("rst_req_valid", 32'(s_rv), 32'd0);
    lat = l;
    reset = 1'b0;
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
  endtask

  initial begin
    int base;
    // Back-to-back fetch with L=1 and decode always ready.
    do_reset(1);
    imem_req_ready = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t1_req_valid", 32'(s_rv), 32'd1);
      chk("t1_if_valid", 32'(s_iv), 32'(k >= 2));
    end

    // Decode stalled: exactly FIFO_DEPTH requests, then drain in order.
    do_reset(1);
    imem_req_ready = 1'b1; if_ready = 1'b0;
    base = n_hs;
    for (int k = 0; k < 20; k++) tick();
    chk("t2_req_count", 32'(n_hs - base), 32'd4);
    chk("t2_req_valid_full", 32'(s_rv), 32'd0);
    chk("t2_if_valid_full", 32'(s_iv), 32'd1);
    if_ready = 1'b1;
    base = n_pop;
    for (int k = 0; k < 12; k++) tick();
    chk("t2_pop_count", 32'(n_pop - base), 32'd12);

    // L=3 with random memory and decode stalls.
    do_reset(3);
    for (int k = 0; k < 300; k++) begin
      imem_req_ready = ($urandom % 3) != 0;
      if_ready       = ($urandom % 4) != 0;
      tick();
    end

    // Redirect to 0x103 with two requests in flight.
    do_reset(3);
    imem_req_ready = 1'b1; if_ready = 1'b1;
    tick(); tick();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; got_first = 1'b0;
    tick();
    chk("t4_if_valid_flushed", 32'(s_iv), 32'd0);
    chk("t4_req_valid", 32'(s_rv), 32'd1);
    chk("t4_req_addr", s_ra, 32'h0000_0100);
    for (int k = 0; k < 15; k++) tick();
    chk("t4_got_first", 32'(got_first), 32'd1);
    chk("t4_first_pc", first_pop_pc, 32'h0000_0100);

    // Redirect coinciding with a response, a request handshake and a decode pop.
    do_reset(1);
    imem_req_ready = 1'b1; if_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    chk("t5_req_valid_at_redirect", 32'(s_rv), 32'd1);
    chk("t5_if_valid_at_redirect", 32'(s_iv), 32'd1);
    redirect_valid = 1'b0; if_ready = 1'b0;
    base = n_hs;
    for (int k = 0; k < 20; k++) tick();
    chk("t5_req_count", 32'(n_hs - base), 32'd4);
    if_ready = 1'b1; got_first = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t5_first_pc", first_pop_pc, 32'h0000_2000);

    // Random stalls with random and back-to-back redirects, including address wrap.
    do_reset(2);
    for (int k = 0; k < 400; k++) begin
      imem_req_ready = ($urandom % 4) != 0;
      if_ready       = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16))
                                             : 32'($urandom_range(0, 32'h0000_0FFF));
      tick();
    end
    redirect_valid = 1'b0;

    // One-cycle reset while the FIFO is full.
    do_reset(1);
    imem_req_ready = 1'b1; if_ready = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("t6_full_before_reset", 32'(s_iv), 32'd1);
    do_reset(1);
    imem_req_ready = 1'b1; if_ready = 1'b1; got_first = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t6_first_pc", first_pop_pc, RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
